// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Signed operations iterate on unsigned magnitudes; the sign is restored in a final fix-up cycle.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             r_state, w_state_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_sign_a, r_sign_b;
    logic [WIDTH-1:0]   r_mag_a, r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_done;

    logic               w_signed_in, w_neg_a, w_neg_b;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next;
    logic [WIDTH-1:0]   w_rem_lo, w_rem_new;
    logic               w_ge;
    logic               w_neg_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_hi_fix, w_lo_fix;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == CW'(WIDTH - 1)) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    assign w_signed_in = ~op[0];
    assign w_neg_a     = w_signed_in & a[WIDTH-1];
    assign w_neg_b     = w_signed_in & b[WIDTH-1];
    assign w_mag_a     = w_neg_a ? -a : a;
    assign w_mag_b     = w_neg_b ? -b : b;

    // Multiply: low half holds the remaining multiplier bits, high half accumulates.
    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
    assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

    // Divide: the remainder's shifted-out MSB forces a subtract, so W-bit arithmetic suffices.
    assign w_rem_lo   = {r_acc[2*WIDTH-2:WIDTH], r_acc[WIDTH-1]};
    assign w_ge       = r_acc[2*WIDTH-1] | (w_rem_lo >= r_mag_b);
    assign w_rem_new  = w_ge ? (w_rem_lo - r_mag_b) : w_rem_lo;
    assign w_div_next = {w_rem_new, r_acc[WIDTH-2:0], w_ge};

    assign w_neg_q  = r_sign_a ^ r_sign_b;
    assign w_prod   = w_neg_q ? -r_acc : r_acc;
    assign w_quo    = w_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_hi_fix = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo_fix = r_is_div ? ((r_mag_b == '0) ? '1 : w_quo) : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_mag_a  <= w_mag_a;
                        r_mag_b  <= w_mag_b;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                        r_cnt    <= '0;
                    end else begin
                        if (mthi) r_hi <= a;
                        if (mtlo) r_lo <= a;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                end
                S_FIX: begin
                    r_hi   <= w_hi_fix;
                    r_lo   <= w_lo_fix;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, hand-built corner sequences and
// random operations checked against a 64-bit arithmetic model.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_vec  = 0;
    int n_fail = 0;

    md_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
    // the remainder follows the dividend, matching the required semantics.
    function automatic void model(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        ua = {32'd0, va};
        ub = {32'd0, vb};
        eh = 32'd0;
        el = 32'd0;
        case (o)
            2'd0: begin sp = sa * sb; {eh, el} = sp; end
            2'd1: begin up = ua * ub; {eh, el} = up; end
            default: begin
                if (vb == 32'd0) begin
                    eh = va;
                    el = 32'hFFFF_FFFF;
                end else if (o == 2'd2) begin
                    sp = sa / sb; el = sp[31:0];
                    sp = sa % sb; eh = sp[31:0];
                end else begin
                    up = ua / ub; el = up[31:0];
                    up = ua % ub; eh = up[31:0];
                end
            end
        endcase
    endfunction

    // kind: 0 plain, 1 second start mid-op, 2 mthi held while busy, 3 mtlo with start
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int kind, input logic [31:0] mid, input string nm);
        int cyc;
        int dones;
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb; mtlo = (kind == 3);
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        cyc = 0; dones = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (done === 1'b1) dones++;
            if (kind == 2 && cyc == 10) chk({nm, " hi held"}, hi, mid);
            if (kind == 3 && cyc == 1)  chk({nm, " lo held"}, lo, mid);
            start = (kind == 1 && cyc == 5);
            mthi  = (kind == 2 && cyc >= 2 && cyc <= 6);
            if (kind == 1) begin
                op = 2'd1; a = 32'd9; b = 32'd9;
            end else if (kind == 2) begin
                a = 32'hAAAA_0000;
            end else begin
                op = 2'($urandom); a = $urandom; b = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0;
        chk({nm, " busy cycles"}, 32'(cyc), 32'd33);
        chk({nm, " done pulse"}, {31'd0, done}, 32'd1);
        chk({nm, " early done"}, 32'(dones), 32'd0);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
        $display("txn %-12s op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h) cycles=%0d",
                 nm, o, va, vb, hi, lo, eh, el, cyc);
        @(negedge clk);
        chk({nm, " done drop"}, {31'd0, done}, 32'd0);
        chk({nm, " busy drop"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, eh, el;
        int          dones, busys;

        tv[0] = '{2'd0, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tv[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        tv[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tv[3] = '{2'd3, 32'd100,       32'd7,          32'd2,         32'd14};
        tv[4] = '{2'd3, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF};
        tv[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
        tv[6] = '{2'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
        tv[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0};
        tv[8] = '{2'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
        tv[9] = '{2'd1, 32'd3,         32'd4,          32'd0,         32'd12};

        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset hi",   hi, 32'd0);
        chk("reset lo",   lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        foreach (tv[i]) run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, 0, 32'd0, "table");

        // mthi and mtlo together while idle
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; a = 32'h55;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; a = 32'h0;
        chk("mthi+mtlo hi", hi, 32'h55);
        chk("mthi+mtlo lo", lo, 32'h55);
        $display("txn mthi+mtlo   a=00000055 -> hi=%h lo=%h", hi, lo);

        run_op(2'd1, 32'd2,   32'd3, 32'd0, 32'd6,  2, 32'h55, "mthi busy");
        run_op(2'd1, 32'd5,   32'd6, 32'd0, 32'd30, 3, 32'd6,  "start+mtlo");
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1, 32'd0,  "restart");

        // asynchronous reset in the middle of a MULT
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'hFFFF_FFFD; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst done", {31'd0, done}, 32'd0);
        chk("async rst hi", hi, 32'd0);
        chk("async rst lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0; busys = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busys++;
        end
        chk("post rst done", 32'(dones), 32'd0);
        chk("post rst busy", 32'(busys), 32'd0);
        $display("txn reset-mid   hi=%h lo=%h done_pulses=%0d", hi, lo, dones);
        run_op(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 0, 32'd0, "after rst");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 20);
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            model(ro, ra, rb, eh, el);
            run_op(ro, ra, rb, eh, el, 0, 32'd0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Operands come straight from the register file read ports (RD1 -> a, RD2 -> b).
- HI/LO are read back by MFHI/MFLO through the writeback mux into the register file.
- Implements MULT, MULTU, DIV, DIVU (shift-add / restoring division, one bit per cycle) plus MTHI/MTLO.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch operation selected by op; accepted only when busy=0
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- mthi  in  1  write a into HI
- mtlo  in  1  write a into LO
- busy  out  1  operation in progress; the core stalls MFHI/MFLO/new MD ops while high
- done  out  1  one-cycle pulse when HI/LO have been updated by an operation
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; hi=lo=0; busy=0; done=0.
  - The in-flight operation is discarded.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0: latch op and operand magnitudes (abs value for signed ops, raw for unsigned); record the sign of a and of b.
  - Clear the internal accumulator/remainder and the iteration counter; go to CALC.
  - busy=1 from after E0.
- CALC:
  - One iteration per edge, E1..E_WIDTH.
  - Multiply: shift-add on a 2*WIDTH product.
  - Divide: restoring shift-subtract on remainder/quotient.
  - After iteration WIDTH, go to FIX.
- FIX, edge E_WIDTH+1:
  - Apply sign correction.
  - Signed multiply: negate the 2*WIDTH product if sign(a)^sign(b).
  - Signed divide: negate the quotient if sign(a)^sign(b); the remainder takes the sign of a.
  - Write hi = product[2W-1:W] / remainder and lo = product[W-1:0] / quotient.
  - busy=0 and done=1 after this edge; done drops the next cycle; go to IDLE.
- Total latency: hi/lo valid and busy low WIDTH+1 cycles after the start edge (33 for WIDTH=32). busy is high for exactly WIDTH+1 cycles.
- start while busy=1: ignored, with no effect on the running operation.
- mthi/mtlo: take effect at the edge only when busy=0 and start=0.
  - Ignored while busy.
  - start has priority over mthi/mtlo in the same cycle.
  - mthi and mtlo together: both written with a.
- HI/LO are otherwise held; they change only at FIX, on mthi/mtlo, or on reset.
- Divide by zero (b=0, DIV or DIVU): full latency, no trap; result hi=a (unmodified dividend), lo={WIDTH{1'b1}}.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Falls out of magnitude arithmetic; no special case.
- Operand magnitude for 0x80000000 in signed ops is 0x80000000 unsigned. Width rules: magnitudes held as unsigned WIDTH bits.
- a and b are only sampled at the start edge; later changes have no effect.

Test Plan:
- Reset mid-operation: MULT started, rst pulsed at cycle 10 -> hi=lo=0, busy=0, done never pulses; a new MULTU 3*4 afterwards -> lo=12, hi=0.
- MULT a=0xFFFFFFFD (-3), b=5 -> after exactly 33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high 33 cycles; done pulses once.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- Divide by zero and overflow: DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Priority/ignore rules:
  - mthi a=0xAAAA0000 while busy -> HI unchanged at completion.
  - Second start mid-operation -> ignored, first result intact.
  - start+mtlo same cycle -> start wins.
  - mthi+mtlo with a=0x55 when idle -> hi=lo=0x55 next cycle.
